// File: rtl/cobra_prog_loader.sv
// -----------------------------------------------------------------------------
// cobra_prog_loader
//
// Boot-time program loader. Holds the processor core in reset, receives a
// byte stream (16-bit little-endian word count followed by little-endian
// 32-bit instruction words), writes each word into instruction memory, then
// releases the core. An over-size length aborts into an error state that is
// held until the next start request.
//
// Optional feature (macro COBRA_LOADER_CHECKSUM_EN): after the last word one
// extra byte is accepted and compared with the XOR of all data bytes; a
// mismatch ends in the error state instead of releasing the core.
//
// Parameters
//   MEM_WORDS     instruction-memory capacity in 32-bit words (power of two)
//
// Ports
//   clk_i         system clock, rising edge
//   rst_i         asynchronous active-low reset
//   start_i       load request, sampled in IDLE/DONE/ERR only
//   byte_i        program stream byte
//   byte_valid_i  byte_i is valid
//   byte_ready_o  loader takes byte_i this cycle when valid
//   mem_we_o      instruction-memory write strobe (one cycle per word)
//   mem_addr_o    word-aligned byte address of the write
//   mem_wdata_o   instruction word to write
//   core_rst_o    active-high core reset, low only once the program is loaded
//   busy_o        load in progress
//   done_o        program loaded, core released
//   err_o         load aborted
// -----------------------------------------------------------------------------
module cobra_prog_loader #(
  parameter int MEM_WORDS = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [7:0]  byte_i,
  input  logic        byte_valid_i,
  output logic        byte_ready_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic        core_rst_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o
);

  // 17 bits so the index can reach MEM_WORDS = 65536 without wrapping.
  localparam int IDX_W = 17;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEN   = 3'd1,
    S_DATA  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4,
`ifdef COBRA_LOADER_CHECKSUM_EN
    S_CSUM  = 3'd6,
`endif
    S_ERR   = 3'd5
  } state_e;

  state_e             state_q,    state_d;
  logic [15:0]        len_q,      len_d;
  logic [IDX_W-1:0]   word_idx_q, word_idx_d;
  logic [1:0]         byte_cnt_q, byte_cnt_d;
  logic [31:0]        data_q,     data_d;
  logic [31:0]        mem_addr_q, mem_addr_d;
  logic [31:0]        mem_wdata_q, mem_wdata_d;
`ifdef COBRA_LOADER_CHECKSUM_EN
  logic [7:0]         csum_q,     csum_d;
`endif

  logic               accept;
  logic [15:0]        len_full;

  assign accept   = byte_valid_i & byte_ready_o;
  // Count as it stands once the high length byte arrives this cycle.
  assign len_full = {byte_i, len_q[7:0]};

  // ---------------------------------------------------------------------------
  // Next-state and datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    state_d     = state_q;
    len_d       = len_q;
    word_idx_d  = word_idx_q;
    byte_cnt_d  = byte_cnt_q;
    data_d      = data_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
`ifdef COBRA_LOADER_CHECKSUM_EN
    csum_d      = csum_q;
`endif

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start_i) begin
          state_d    = S_LEN;
          len_d      = '0;
          word_idx_d = '0;
          byte_cnt_d = '0;
          data_d     = '0;
`ifdef COBRA_LOADER_CHECKSUM_EN
          csum_d     = '0;
`endif
        end
      end

      S_LEN: begin
        if (accept) begin
          if (byte_cnt_q == 2'd0) begin
            len_d[7:0] = byte_i;
            byte_cnt_d = 2'd1;
          end else begin
            len_d      = len_full;
            byte_cnt_d = 2'd0;
            if (len_full == 16'd0) begin
              state_d = S_DONE;
            end else if ({1'b0, len_full} > IDX_W'(MEM_WORDS)) begin
              state_d = S_ERR;
            end else begin
              state_d = S_DATA;
            end
          end
        end
      end

      S_DATA: begin
        if (accept) begin
          data_d[8*byte_cnt_q +: 8] = byte_i;
          byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef COBRA_LOADER_CHECKSUM_EN
          csum_d     = csum_q ^ byte_i;
`endif
          if (byte_cnt_q == 2'd3) begin
            // Capture address and word now so both are stable flops
            // throughout the write cycle.
            mem_addr_d  = {13'd0, word_idx_q, 2'b00};
            mem_wdata_d = data_d;
            state_d     = S_WRITE;
          end
        end
      end

      S_WRITE: begin
        word_idx_d = word_idx_q + IDX_W'(1);
        if (word_idx_d == {1'b0, len_q}) begin
`ifdef COBRA_LOADER_CHECKSUM_EN
          state_d = S_CSUM;
`else
          state_d = S_DONE;
`endif
        end else begin
          state_d = S_DATA;
        end
      end

`ifdef COBRA_LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (accept) begin
          state_d = (byte_i == csum_q) ? S_DONE : S_ERR;
        end
      end
`endif

      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode (from registered state only)
  // ---------------------------------------------------------------------------
  always_comb begin
    byte_ready_o = 1'b0;
    mem_we_o     = 1'b0;
    busy_o       = 1'b0;
    core_rst_o   = 1'b1;
    done_o       = 1'b0;
    err_o        = 1'b0;
    case (state_q)
      S_LEN, S_DATA: begin
        byte_ready_o = 1'b1;
        busy_o       = 1'b1;
      end
`ifdef COBRA_LOADER_CHECKSUM_EN
      S_CSUM: begin
        byte_ready_o = 1'b1;
        busy_o       = 1'b1;
      end
`endif
      S_WRITE: begin
        mem_we_o = 1'b1;
        busy_o   = 1'b1;
      end
      S_DONE: begin
        core_rst_o = 1'b0;
        done_o     = 1'b1;
      end
      S_ERR:   err_o = 1'b1;
      default: ;
    endcase
  end

  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: the data and address registers are reset along with the control
  // state because their values are visible on the memory port during reset.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      word_idx_q  <= '0;
      byte_cnt_q  <= '0;
      data_q      <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q     <= state_d;
      len_q       <= len_d;
      word_idx_q  <= word_idx_d;
      byte_cnt_q  <= byte_cnt_d;
      data_q      <= data_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

`ifdef COBRA_LOADER_CHECKSUM_EN
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      csum_q <= '0;
    end else begin
      csum_q <= csum_d;
    end
  end
`endif

endmodule

// File: tb/tb_cobra_prog_loader.sv
// -----------------------------------------------------------------------------
// tb_cobra_prog_loader
//
// Directed bench for cobra_prog_loader (MEM_WORDS = 1024). Inputs change 1 ns
// after a rising edge; outputs are sampled on the falling edge or a few ns
// after an edge. A negedge monitor logs every memory write and flags any
// write pulse longer than one cycle or any write with byte_ready_o high.
// Checksum scenarios are built only when COBRA_LOADER_CHECKSUM_EN is defined.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_cobra_prog_loader;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [7:0]  byte_i;
  logic        byte_valid_i;
  logic        byte_ready_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        core_rst_o;
  logic        busy_o;
  logic        done_o;
  logic        err_o;

  int checks = 0;
  int errors = 0;
  int viol   = 0;
  bit gaps   = 1'b0;
  logic prev_we = 1'b0;

  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];

  logic [7:0] prog2 [10] = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h00, 8'h00,
                             8'h93, 8'h05, 8'h10, 8'h00};

  cobra_prog_loader #(.MEM_WORDS(1024)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .byte_i       (byte_i),
    .byte_valid_i (byte_valid_i),
    .byte_ready_o (byte_ready_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .core_rst_o   (core_rst_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .err_o        (err_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // Write monitor
  always @(negedge clk_i) begin
    if (!rst_i) begin
      prev_we = 1'b0;
    end else begin
      if (mem_we_o) begin
        wr_addr_q.push_back(mem_addr_o);
        wr_data_q.push_back(mem_wdata_o);
        if (byte_ready_o) viol++;
        if (prev_we) viol++;
      end
      prev_we = mem_we_o;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    wr_addr_q.delete();
    wr_data_q.delete();
  endtask

  task automatic do_start();
    @(posedge clk_i); #1;
    start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
  endtask

  // Present one byte and hold it until accepted (bounded wait).
  task automatic send_byte(input logic [7:0] b);
    int n;
    int budget;
    n = 0;
    if (gaps) begin
      while ($urandom_range(1) == 0 && n < 8) begin
        byte_valid_i = 1'b0;
        byte_i       = 8'($urandom);
        @(posedge clk_i); #1;
        n++;
      end
    end
    byte_i       = b;
    byte_valid_i = 1'b1;
    budget       = 0;
    @(negedge clk_i);
    while (!byte_ready_o && budget < 50) begin
      @(negedge clk_i);
      budget++;
    end
    if (!byte_ready_o) begin
      check("send_timeout", {31'd0, byte_ready_o}, 32'd1);
      byte_valid_i = 1'b0;
    end else begin
      @(posedge clk_i); #1;
      byte_valid_i = 1'b0;
    end
  endtask

  // Two-word program; expects writes (0x0,0x00000513),(0x4,0x00100593).
  task automatic run_prog2(input string tag);
    clear_log();
    do_start();
    check({tag, "_busy_in_len"}, {31'd0, busy_o}, 32'd1);
    for (int i = 0; i < 10; i++) send_byte(prog2[i]);
    @(negedge clk_i);
    check({tag, "_we"},    {31'd0, mem_we_o},     32'd1);
    check({tag, "_rdy_we"}, {31'd0, byte_ready_o}, 32'd0);
    check({tag, "_addr1"}, mem_addr_o,  32'h0000_0004);
    check({tag, "_data1"}, mem_wdata_o, 32'h0010_0593);
`ifdef COBRA_LOADER_CHECKSUM_EN
    send_byte(8'h90);
`endif
    @(negedge clk_i);
    check({tag, "_done"},     {31'd0, done_o},     32'd1);
    check({tag, "_core_rst"}, {31'd0, core_rst_o}, 32'd0);
    check({tag, "_busy"},     {31'd0, busy_o},     32'd0);
    check({tag, "_nwr"}, 32'(wr_addr_q.size()), 32'd2);
    if (wr_addr_q.size() >= 2) begin
      check({tag, "_wa0"}, wr_addr_q[0], 32'h0000_0000);
      check({tag, "_wd0"}, wr_data_q[0], 32'h0000_0513);
      check({tag, "_wa1"}, wr_addr_q[1], 32'h0000_0004);
      check({tag, "_wd1"}, wr_data_q[1], 32'h0010_0593);
    end
    check({tag, "_viol"}, 32'(viol), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"},    {31'd0, byte_ready_o}, 32'd0);
    check({tag, "_we"},       {31'd0, mem_we_o},     32'd0);
    check({tag, "_addr"},     mem_addr_o,            32'd0);
    check({tag, "_wdata"},    mem_wdata_o,           32'd0);
    check({tag, "_core_rst"}, {31'd0, core_rst_o},   32'd1);
    check({tag, "_busy"},     {31'd0, busy_o},       32'd0);
    check({tag, "_done"},     {31'd0, done_o},       32'd0);
    check({tag, "_err"},      {31'd0, err_o},        32'd0);
  endtask

  initial begin
    rst_i        = 1'b0;
    start_i      = 1'b0;
    byte_i       = 8'h00;
    byte_valid_i = 1'b0;

    // Reset values
    #3;
    check_reset_outputs("rst");
    #9 rst_i = 1'b1;
    @(negedge clk_i);
    check("idle_busy",     {31'd0, busy_o},     32'd0);
    check("idle_core_rst", {31'd0, core_rst_o}, 32'd1);

    // Basic two-word load
    run_prog2("p2");

    // Zero length: DONE right after the two length bytes, no writes
    clear_log();
    do_start();
    check("z_core_rst_during", {31'd0, core_rst_o}, 32'd1);
    send_byte(8'h00);
    send_byte(8'h00);
    @(negedge clk_i);
    check("z_done",     {31'd0, done_o},     32'd1);
    check("z_core_rst", {31'd0, core_rst_o}, 32'd0);
    check("z_busy",     {31'd0, busy_o},     32'd0);
    check("z_nwr", 32'(wr_addr_q.size()), 32'd0);

    // Over-size length 1025 -> ERR, held until next start
    clear_log();
    do_start();
    send_byte(8'h01);
    send_byte(8'h04);
    @(negedge clk_i);
    check("big_err",      {31'd0, err_o},        32'd1);
    check("big_core_rst", {31'd0, core_rst_o},   32'd1);
    check("big_ready",    {31'd0, byte_ready_o}, 32'd0);
    check("big_done",     {31'd0, done_o},       32'd0);
    check("big_busy",     {31'd0, busy_o},       32'd0);
    repeat (5) @(negedge clk_i);
    check("big_err_hold", {31'd0, err_o}, 32'd1);
    check("big_nwr", 32'(wr_addr_q.size()), 32'd0);

    // Same two-word load with random valid gaps
    gaps = 1'b1;
    run_prog2("gap");
    gaps = 1'b0;

    // Full capacity: N = 1024, word i = i
    clear_log();
    do_start();
    check("full_err_cleared", {31'd0, err_o}, 32'd0);
    send_byte(8'h00);
    send_byte(8'h04);
    for (int i = 0; i < 1024; i++) begin
      send_byte(8'(i));
      send_byte(8'(i >> 8));
      send_byte(8'h00);
      send_byte(8'h00);
    end
    @(negedge clk_i);
    check("full_we",   {31'd0, mem_we_o}, 32'd1);
    check("full_addr", mem_addr_o,  32'h0000_0FFC);
    check("full_data", mem_wdata_o, 32'h0000_03FF);
`ifdef COBRA_LOADER_CHECKSUM_EN
    send_byte(8'h00);
`endif
    @(negedge clk_i);
    check("full_done", {31'd0, done_o}, 32'd1);
    check("full_nwr", 32'(wr_addr_q.size()), 32'd1024);
    if (wr_addr_q.size() == 1024) begin
      check("full_wa512", wr_addr_q[512], 32'h0000_0800);
      check("full_wd512", wr_data_q[512], 32'h0000_0200);
    end
    check("full_viol", 32'(viol), 32'd0);

    // Reset during the write of word 1
    clear_log();
    do_start();
    for (int i = 0; i < 10; i++) send_byte(prog2[i]);
    check("mid_we_before", {31'd0, mem_we_o}, 32'd1);
    #1 rst_i = 1'b0;
    #1;
    check_reset_outputs("mid");
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    check("mid_idle_busy",     {31'd0, busy_o},       32'd0);
    check("mid_idle_ready",    {31'd0, byte_ready_o}, 32'd0);
    check("mid_idle_core_rst", {31'd0, core_rst_o},   32'd1);
    check("mid_idle_done",     {31'd0, done_o},       32'd0);
    check("mid_nwr", 32'(wr_addr_q.size()), 32'd1);
    do_start();
    check("mid_restart_busy", {31'd0, busy_o}, 32'd1);
    send_byte(8'h00);
    send_byte(8'h00);

`ifdef COBRA_LOADER_CHECKSUM_EN
    // Checksum good: 11^22^33^44 = 44
    clear_log();
    do_start();
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    @(negedge clk_i);
    check("cs_we",   {31'd0, mem_we_o}, 32'd1);
    check("cs_data", mem_wdata_o, 32'h4433_2211);
    send_byte(8'h44);
    @(negedge clk_i);
    check("cs_done", {31'd0, done_o}, 32'd1);
    check("cs_err",  {31'd0, err_o},  32'd0);

    // Checksum bad
    clear_log();
    do_start();
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    send_byte(8'h45);
    @(negedge clk_i);
    check("csb_err",  {31'd0, err_o},  32'd1);
    check("csb_done", {31'd0, done_o}, 32'd0);
    check("csb_nwr", 32'(wr_addr_q.size()), 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
